// File: rtl/kart_pkg.sv
// Shared kart-state word layout: field positions, packed view of the word and
// the default liveness timeout (100 ms of 65 MHz video clock).
package kart_pkg;

    localparam int WORD_W    = 44;
    localparam int X_MSB     = 43;
    localparam int X_LSB     = 33;
    localparam int Y_MSB     = 31;
    localparam int Y_LSB     = 21;
    localparam int DIR_MSB   = 19;
    localparam int DIR_LSB   = 11;
    localparam int GAME_MSB  = 7;
    localparam int GAME_LSB  = 5;
    localparam int RST_BIT   = 3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 6_500_000;

    // Unused gaps between fields are kept so the struct overlays the raw word.
    typedef struct packed {
        logic [X_MSB-X_LSB:0]       x;
        logic                       pad_32;
        logic [Y_MSB-Y_LSB:0]       y;
        logic                       pad_20;
        logic [DIR_MSB-DIR_LSB:0]   dir;
        logic [2:0]                 pad_10_8;
        logic [GAME_MSB-GAME_LSB:0] game;
        logic                       pad_4;
        logic                       rst;
        logic [2:0]                 pad_2_0;
    } kart_state_t;

endpackage

// File: rtl/liveness_timer.sv
// Per-player saturating age counter; alive drops in the same cycle the age
// reaches TIMEOUT_CYCLES and is restored by any refresh.
module liveness_timer #(
    parameter int TIMEOUT_CYCLES = kart_pkg::DEFAULT_TIMEOUT_CYCLES,
    parameter int AGE_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic refresh,
    output logic alive
);

    logic [AGE_W-1:0] age_q, age_d;
    logic             alive_q, alive_d;

    always_comb begin
        age_d   = age_q;
        alive_d = alive_q;
        if (refresh) begin
            age_d   = '0;
            alive_d = 1'b1;
        end else if (age_q != AGE_W'(TIMEOUT_CYCLES)) begin
            age_d = age_q + AGE_W'(1);
            if (age_d == AGE_W'(TIMEOUT_CYCLES)) begin
                alive_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            age_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            age_q   <= age_d;
            alive_q <= alive_d;
        end
    end

    assign alive = alive_q;

endmodule

// File: rtl/opponent_state_table.sv
// Per-player table of remote kart-state words with change filtering, link
// liveness and a frame-consistent shadow copy read by game and graphics.
module opponent_state_table #(
    parameter int NUM_PLAYERS    = 4,
    parameter int WORD_WIDTH     = kart_pkg::WORD_W,
    parameter int RST_BIT        = kart_pkg::RST_BIT,
    parameter int TIMEOUT_CYCLES = kart_pkg::DEFAULT_TIMEOUT_CYCLES,
    parameter int PID_W          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   axiiv,
    input  logic [WORD_WIDTH-1:0]  axiid,
    input  logic [PID_W-1:0]       axiid_pid,
    input  logic                   frame_in,
    input  logic [PID_W-1:0]       rd_pid,
    output logic [WORD_WIDTH-1:0]  rd_data,
    output logic                   rd_alive,
    output logic [NUM_PLAYERS-1:0] alive_mask,
    output logic                   remote_rst_out,
    output logic [15:0]            update_count
);

    logic [WORD_WIDTH-1:0]  word_q [NUM_PLAYERS];
    logic [WORD_WIDTH-1:0]  word_d [NUM_PLAYERS];
    logic [WORD_WIDTH-1:0]  shadow_q [NUM_PLAYERS];
    logic [WORD_WIDTH-1:0]  shadow_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] shadow_alive_q, shadow_alive_d;
    logic [NUM_PLAYERS-1:0] refresh;
    logic [NUM_PLAYERS-1:0] accept;
    logic [NUM_PLAYERS-1:0] alive_w;
    logic [WORD_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                   rd_alive_q, rd_alive_d;
    logic                   remote_rst_q, remote_rst_d;
    logic [15:0]            update_count_q, update_count_d;

    // Pid matching is done per entry, so out-of-range pids simply hit nothing.
    always_comb begin
        refresh        = '0;
        accept         = '0;
        word_d         = word_q;
        shadow_d       = shadow_q;
        shadow_alive_d = shadow_alive_q;
        remote_rst_d   = 1'b0;
        update_count_d = update_count_q;
        rd_data_d      = '0;
        rd_alive_d     = 1'b0;

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (axiiv && (axiid != '0) && (axiid_pid == PID_W'(i))) begin
                refresh[i] = 1'b1;
                if (axiid != word_q[i]) begin
                    accept[i] = 1'b1;
                    word_d[i] = axiid;
                end
            end
        end

        if (|refresh) begin
            remote_rst_d = axiid[RST_BIT];
        end
        if (|accept) begin
            update_count_d = update_count_q + 16'd1;
        end

        // Snapshot takes the pre-update table so a same-cycle write waits a frame.
        if (frame_in) begin
            shadow_d       = word_q;
            shadow_alive_d = alive_w;
        end

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (rd_pid == PID_W'(i)) begin
                rd_data_d  = shadow_q[i];
                rd_alive_d = shadow_alive_q[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            word_q         <= '{default: '0};
            shadow_q       <= '{default: '0};
            shadow_alive_q <= '0;
            rd_data_q      <= '0;
            rd_alive_q     <= 1'b0;
            remote_rst_q   <= 1'b0;
            update_count_q <= '0;
        end else begin
            word_q         <= word_d;
            shadow_q       <= shadow_d;
            shadow_alive_q <= shadow_alive_d;
            rd_data_q      <= rd_data_d;
            rd_alive_q     <= rd_alive_d;
            remote_rst_q   <= remote_rst_d;
            update_count_q <= update_count_d;
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_timer
        liveness_timer #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_timer (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .refresh(refresh[g]),
            .alive  (alive_w[g])
        );
    end

    assign alive_mask     = alive_w;
    assign rd_data        = rd_data_q;
    assign rd_alive       = rd_alive_q;
    assign remote_rst_out = remote_rst_q;
    assign update_count   = update_count_q;

endmodule
